// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: shares one SD SPI block reader between the audio
// streamer (A) and the tile loader (V). One 512-byte block read is granted
// at a time; returned bytes and completion status go to the owner only.
module sd_block_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned GAP_CYCLES     = 4
) (
  input  logic              MasterCLK,
  input  logic              Reset,
  // audio requester
  input  logic              A_Req,
  input  logic              A_Urgent,
  input  logic [ADDR_W-1:0] A_Addr,
  output logic              A_Grant,
  output logic              A_DataValid,
  output logic              A_Done,
  output logic              A_Err,
  // video requester
  input  logic              V_Req,
  input  logic [ADDR_W-1:0] V_Addr,
  output logic              V_Grant,
  output logic              V_DataValid,
  output logic              V_Done,
  output logic              V_Err,
  // shared byte path
  output logic [7:0]        RdData,
  // SD reader side
  output logic              SD_CmdValid,
  input  logic              SD_CmdReady,
  output logic [ADDR_W-1:0] SD_CmdAddr,
  input  logic              SD_DataValid,
  input  logic [7:0]        SD_Data,
  input  logic              SD_BlockDone,
  output logic              SD_Abort
);

  localparam int unsigned BW = $clog2(BLOCK_BYTES) + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BW-1:0] BLOCK_N    = BW'(BLOCK_BYTES);
  localparam logic [BW-1:0] BLOCK_LAST = BW'(BLOCK_BYTES - 1);
  localparam logic [TW-1:0] TO_N       = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_N      = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_DONE,
    S_GAP
  } state_t;

  state_t state, state_d;

  logic              owner_v;   // 1: video owns the reader
  logic              prio_v;    // 1: video wins a non-urgent tie
  logic              dv_q;
  logic              err_q;
  logic [7:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     byte_cnt;
  logic [TW-1:0]     to_cnt;
  logic [GW-1:0]     gap_cnt;

  logic a_wins, v_wins;
  logic start, accept, fwd, abort;
  logic overflow, last_byte, busy;

  // Arbitration: urgent audio first, then lone requester, then round-robin.
  always_comb begin
    a_wins = A_Req & (A_Urgent | ~V_Req | ~prio_v);
    v_wins = V_Req & ~a_wins;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state;
    start     = 1'b0;
    accept    = 1'b0;
    fwd       = 1'b0;
    abort     = 1'b0;
    overflow  = SD_DataValid && (byte_cnt == BLOCK_N);
    last_byte = SD_DataValid && (byte_cnt == BLOCK_LAST);
    case (state)
      S_IDLE: begin
        if (A_Req || V_Req) begin
          start   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (SD_CmdReady) begin
          accept  = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        fwd = SD_DataValid && !overflow;
        if (overflow) begin
          abort = 1'b1;
        end else if (SD_BlockDone) begin
          if ((!SD_DataValid && byte_cnt == BLOCK_N) || last_byte) begin
            state_d = S_DONE;
          end else begin
            abort = 1'b1;
          end
        end else if (!SD_DataValid && to_cnt <= TW'(1)) begin
          // Counter reaching zero means TIMEOUT_CYCLES idle cycles elapsed.
          abort = 1'b1;
        end
        if (abort) begin
          state_d = S_GAP;
        end
      end
      S_DONE: begin
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt <= GW'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register, ownership latch, byte path and counters.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      owner_v  <= 1'b0;
      prio_v   <= 1'b0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
      addr_q   <= '0;
      byte_cnt <= '0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_d;
      dv_q  <= fwd;
      err_q <= abort;
      if (fwd) begin
        rd_q <= SD_Data;
      end
      if (start) begin
        owner_v <= v_wins;
        addr_q  <= v_wins ? V_Addr : A_Addr;
      end
      if (accept) begin
        byte_cnt <= '0;
        to_cnt   <= TO_N;
      end else if (fwd) begin
        byte_cnt <= byte_cnt + BW'(1);
        to_cnt   <= TO_N;
      end else if (state == S_STREAM && to_cnt != '0) begin
        to_cnt <= to_cnt - TW'(1);
      end
      if (state == S_DONE) begin
        prio_v <= ~owner_v;
      end
      if (state != S_GAP && state_d == S_GAP) begin
        gap_cnt <= GAP_N;
      end else if (state == S_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

  // Output decode: everything is steered by the registered owner.
  always_comb begin
    busy        = (state == S_ISSUE) || (state == S_STREAM) || (state == S_DONE);
    A_Grant     = busy & ~owner_v;
    V_Grant     = busy & owner_v;
    A_DataValid = dv_q & ~owner_v;
    V_DataValid = dv_q & owner_v;
    A_Done      = (state == S_DONE) & ~owner_v;
    V_Done      = (state == S_DONE) & owner_v;
    A_Err       = err_q & ~owner_v;
    V_Err       = err_q & owner_v;
    SD_Abort    = err_q;
    SD_CmdValid = (state == S_ISSUE);
    SD_CmdAddr  = addr_q;
    RdData      = rd_q;
  end

endmodule
